// File: rtl/bfp16_pkg.sv
// Shared BFP16 types and constants for the weight-stationary PE column.
// Optional weight prefetch is enabled with the BFP16_PE_COL_PREFETCH_EN macro.
package bfp16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bfp16_t;

  localparam int          BIAS       = 127;
  localparam logic [15:0] MAX_FINITE = 16'h7F7F;
  localparam logic [15:0] ZERO       = 16'h0000;

  typedef enum logic [1:0] {
    LD_EMPTY,
    LD_LOADING,
    LD_LOADED
  } ld_state_e;

endpackage

// File: rtl/bfp16_mac_pe.sv
// One PE stage: BFP16 multiply-add into a registered psum, plus the weight register(s).
// With BFP16_PE_COL_PREFETCH_EN a shadow weight register is chained and copied on swap.
module bfp16_mac_pe (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] wt_in,
  input  logic        wt_shift,
`ifdef BFP16_PE_COL_PREFETCH_EN
  input  logic        wt_swap,
`endif
  output logic [15:0] wt_out,
  input  logic [15:0] psum_in,
  input  logic        vld_in,
  input  logic [15:0] lane_in,
  output logic [15:0] psum_out,
  output logic        vld_out,
  output logic [15:0] lane_out
);
  import bfp16_pkg::*;

  function automatic logic [15:0] pack_rne(input logic sign, input int e_in,
                                           input logic [6:0] frac, input logic g, input logic s);
    logic [7:0] m;
    int         e;
    e = e_in;
    m = {1'b0, frac} + 8'(g & (s | frac[0]));
    if (m[7]) e = e + 1;
    if (e >= 255) return {sign, MAX_FINITE[14:0]};
    if (e <= 0) return ZERO;
    return {sign, e[7:0], m[6:0]};
  endfunction

  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    bfp16_t      x, y;
    logic [15:0] p;
    logic        sign;
    int          e;
    x = a;
    y = b;
    sign = x.sign ^ y.sign;
    if (x.exp == 8'hFF || y.exp == 8'hFF) return {sign, MAX_FINITE[14:0]};
    if (x.exp == 8'h00 || y.exp == 8'h00) return ZERO;
    p = 16'({1'b1, x.frac}) * 16'({1'b1, y.frac});
    e = int'(x.exp) + int'(y.exp) - BIAS;
    if (p[15]) return pack_rne(sign, e + 1, p[14:8], p[7], |p[6:0]);
    return pack_rne(sign, e, p[13:7], p[6], |p[5:0]);
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    bfp16_t      x, y, big, sml;
    logic [15:0] mb, ms, lost;
    logic [16:0] sum;
    logic        found;
    int          d, e, lz;
    x = a;
    y = b;
    if (x.exp == 8'hFF) return {x.sign, MAX_FINITE[14:0]};
    if (y.exp == 8'hFF) return {y.sign, MAX_FINITE[14:0]};
    if (x.exp == 8'h00 && y.exp == 8'h00) return ZERO;
    if (x.exp == 8'h00) return b;
    if (y.exp == 8'h00) return a;
    if ({x.exp, x.frac} >= {y.exp, y.frac}) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    d  = int'(big.exp) - int'(sml.exp);
    e  = int'(big.exp);
    mb = {1'b1, big.frac, 8'h00};
    ms = {1'b1, sml.frac, 8'h00};
    // Bits shifted out of the smaller operand are jammed into bit 0 as sticky.
    if (d >= 16) begin
      ms = 16'h0001;
    end else begin
      lost = ms & ((16'h1 << d) - 16'h1);
      ms   = (ms >> d) | {15'h0, |lost};
    end
    if (big.sign == sml.sign) begin
      sum = {1'b0, mb} + {1'b0, ms};
      if (sum[16]) return pack_rne(big.sign, e + 1, sum[15:9], sum[8], |sum[7:0]);
      return pack_rne(big.sign, e, sum[14:8], sum[7], |sum[6:0]);
    end
    mb = mb - ms;
    if (mb == 16'h0000) return ZERO;
    lz    = 0;
    found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (!found) begin
        if (mb[i]) found = 1'b1;
        else lz = lz + 1;
      end
    end
    mb = mb << lz;
    return pack_rne(big.sign, e - lz, mb[14:8], mb[7], |mb[6:0]);
  endfunction

  logic [15:0] psum_q, psum_d, lane_q, lane_d, wt_act_q, wt_act_d;
  logic        vld_q, vld_d;
`ifdef BFP16_PE_COL_PREFETCH_EN
  logic [15:0] wt_shd_q, wt_shd_d;
`endif

  always_comb begin
    psum_d = vld_in ? fadd(psum_in, fmul(wt_act_q, lane_in)) : ZERO;
    vld_d  = vld_in;
    lane_d = lane_in;
`ifdef BFP16_PE_COL_PREFETCH_EN
    wt_shd_d = wt_shift ? wt_in : wt_shd_q;
    wt_act_d = wt_swap ? wt_shd_q : wt_act_q;
    wt_out   = wt_shd_q;
`else
    wt_act_d = wt_shift ? wt_in : wt_act_q;
    wt_out   = wt_act_q;
`endif
  end

  // Stage boundary: psum/valid/lane and weight registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      psum_q   <= ZERO;
      vld_q    <= 1'b0;
      lane_q   <= 16'h0000;
      wt_act_q <= 16'h0000;
`ifdef BFP16_PE_COL_PREFETCH_EN
      wt_shd_q <= 16'h0000;
`endif
    end else begin
      psum_q   <= psum_d;
      vld_q    <= vld_d;
      lane_q   <= lane_d;
      wt_act_q <= wt_act_d;
`ifdef BFP16_PE_COL_PREFETCH_EN
      wt_shd_q <= wt_shd_d;
`endif
    end
  end

  assign psum_out = psum_q;
  assign vld_out  = vld_q;
  assign lane_out = lane_q;

endmodule

// File: rtl/bfp16_ws_pe_col_gen.sv
// Weight-stationary BFP16 PE column of DEPTH stages; psums flow from stage DEPTH-1 to 0.
// Define BFP16_PE_COL_PREFETCH_EN to load a shadow weight chain and swap it in when idle.
module bfp16_ws_pe_col_gen #(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wt_valid,
  output logic                  wt_ready,
  input  logic [15:0]           wt_data,
  output logic                  wt_loaded,
  input  logic                  wt_swap,
  input  logic                  in_valid,
  input  logic [15:0]           psum_in,
  input  logic [16*DEPTH-1:0]   ifmap,
  output logic [16*DEPTH-1:0]   out_ifmap,
  output logic                  out_valid,
  output logic [15:0]           out,
  output logic                  busy
);
  import bfp16_pkg::*;

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0] psum_c [DEPTH+1];
  logic [15:0] wt_c   [DEPTH+1];
  logic        vld_c  [DEPTH+1];
  ld_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        wt_acc, chain_full;
  logic [15:0] unused_wt;

  assign psum_c[DEPTH] = psum_in;
  assign wt_c[DEPTH]   = wt_data;
  assign vld_c[DEPTH]  = in_valid & wt_loaded;
  assign out           = psum_c[0];
  assign out_valid     = vld_c[0];
  assign unused_wt     = wt_c[0];
  assign chain_full    = (state_q == LD_LOADED);
  assign wt_acc        = wt_valid & wt_ready;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) busy = busy | vld_c[k];
  end

`ifdef BFP16_PE_COL_PREFETCH_EN
  logic swap_acc, act_loaded_q, act_loaded_d;
  assign wt_ready  = ~chain_full;
  assign swap_acc  = wt_swap & chain_full & ~busy & ~in_valid;
  assign wt_loaded = act_loaded_q;
  always_comb act_loaded_d = act_loaded_q | swap_acc;
  always_ff @(posedge clk) begin
    if (!rst) act_loaded_q <= 1'b0;
    else      act_loaded_q <= act_loaded_d;
  end
`else
  logic unused_swap;
  assign unused_swap = wt_swap;
  // Reloading is only allowed with an empty pipeline so in-flight tokens see stable weights.
  assign wt_ready  = ~busy & ~in_valid;
  assign wt_loaded = chain_full;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wt_acc) begin
      if (cnt_q == CW'(DEPTH - 1)) begin
        cnt_d   = '0;
        state_d = LD_LOADED;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = LD_LOADING;
      end
    end
`ifdef BFP16_PE_COL_PREFETCH_EN
    if (swap_acc) state_d = LD_EMPTY;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LD_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    bfp16_mac_pe u_pe (
      .clk      (clk),
      .rst      (rst),
      .wt_in    (wt_c[k+1]),
      .wt_shift (wt_acc),
`ifdef BFP16_PE_COL_PREFETCH_EN
      .wt_swap  (swap_acc),
`endif
      .wt_out   (wt_c[k]),
      .psum_in  (psum_c[k+1]),
      .vld_in   (vld_c[k+1]),
      .lane_in  (ifmap[16*k +: 16]),
      .psum_out (psum_c[k]),
      .vld_out  (vld_c[k]),
      .lane_out (out_ifmap[16*k +: 16])
    );
  end

endmodule

// File: tb/tb_bfp16_ws_pe_col_gen.sv
// Directed testbench for the BFP16 weight-stationary PE column (DEPTH=8).
module tb_bfp16_ws_pe_col_gen;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                wt_valid, wt_swap, in_valid;
  logic [15:0]         wt_data, psum_in;
  logic [16*DEPTH-1:0] ifmap;
  logic                wt_ready, wt_loaded, out_valid, busy;
  logic [16*DEPTH-1:0] out_ifmap;
  logic [15:0]         out;

  int checks = 0;
  int errors = 0;

  bfp16_ws_pe_col_gen #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .wt_loaded(wt_loaded), .wt_swap(wt_swap), .in_valid(in_valid), .psum_in(psum_in),
    .ifmap(ifmap), .out_ifmap(out_ifmap), .out_valid(out_valid), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [15:0] v);
    for (int k = 0; k < DEPTH; k++) ifmap[16*k +: 16] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0; wt_valid = 1'b0; wt_swap = 1'b0; in_valid = 1'b0;
    wt_data = 16'h0; psum_in = 16'h0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic load_weights(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      wt_valid = 1'b1; wt_data = w;
      tick();
    end
    wt_valid = 1'b0;
  endtask

  // Single token; checks that out appears exactly DEPTH cycles later with the expected value.
  task automatic run_token(input string name, input logic [15:0] ps, input logic [15:0] want);
    in_valid = 1'b1; psum_in = ps;
    tick();
    in_valid = 1'b0; psum_in = 16'h0;
    for (int c = 2; c <= DEPTH; c++) tick();
    checks++;
    if (out_valid !== 1'b1 || out !== want) begin
      errors++;
      $display("FAIL %s: out_valid=%b out=%h, want valid=1 out=%h", name, out_valid, out, want);
    end
    tick();
  endtask

  task automatic test_reset();
    logic [16*DEPTH-1:0] pat;
    for (int k = 0; k < DEPTH; k++) pat[16*k +: 16] = 16'h1000 + 16'(k);
    ifmap = pat;
    do_reset();
    checks++;
    if ({out_valid, out, busy, wt_loaded} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outs: valid=%b out=%h busy=%b loaded=%b, want all 0", out_valid, out, busy, wt_loaded);
    end
    checks++;
    if (out_ifmap !== '0) begin errors++; $display("FAIL reset_ifmap: got %h want 0", out_ifmap); end
    checks++;
    if (wt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wt_ready); end
    tick();
    checks++;
    if (out_ifmap !== pat) begin errors++; $display("FAIL ifmap_fwd: got %h want %h", out_ifmap, pat); end
    set_lanes(16'h0);
  endtask

`ifdef BFP16_PE_COL_PREFETCH_EN
  task automatic test_prefetch();
    int n;
    do_reset();
    load_weights(16'h3F80, DEPTH);
    checks++;
    if (wt_loaded !== 1'b0 || wt_ready !== 1'b0) begin
      errors++; $display("FAIL shadow_full: loaded=%b ready=%b want 0 0", wt_loaded, wt_ready);
    end
    wt_swap = 1'b1; tick(); wt_swap = 1'b0;
    checks++;
    if (wt_loaded !== 1'b1) begin errors++; $display("FAIL swap1: loaded=%b want 1", wt_loaded); end
    set_lanes(16'h3F80);
    for (int c = 0; c < DEPTH; c++) begin
      in_valid = 1'b1; psum_in = 16'h0; wt_valid = 1'b1; wt_data = 16'h4000;
      tick();
    end
    in_valid = 1'b0; wt_valid = 1'b0; wt_swap = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h4100) begin
      errors++; $display("FAIL stream_out: valid=%b out=%h want 1 4100", out_valid, out);
    end
    tick(); tick();
    checks++;
    if (wt_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL swap_hold: ready=%b busy=%b want 0 1", wt_ready, busy);
    end
    n = 0;
    while (wt_ready !== 1'b1 && n < 40) begin tick(); n++; end
    wt_swap = 1'b0;
    checks++;
    if (wt_ready !== 1'b1) begin errors++; $display("FAIL swap_drain: ready=%b want 1", wt_ready); end
    run_token("prefetch_out", 16'h0000, 16'h4180);
  endtask
`else
  task automatic test_load();
    do_reset();
    load_weights(16'h3F80, DEPTH - 1);
    checks++;
    if (wt_loaded !== 1'b0) begin errors++; $display("FAIL load7: loaded=%b want 0", wt_loaded); end
    load_weights(16'h3F80, 1);
    checks++;
    if (wt_loaded !== 1'b1) begin errors++; $display("FAIL load8: loaded=%b want 1", wt_loaded); end
  endtask

  task automatic test_compute_skewed();
    logic [16:0] want;
    for (int c = 0; c < DEPTH + 2; c++) begin
      in_valid = (c == 0); psum_in = 16'h0;
      for (int k = 0; k < DEPTH; k++) ifmap[16*k +: 16] = (c == DEPTH - 1 - k) ? 16'h3F80 : 16'h0;
      tick();
      want = (c + 1 == DEPTH) ? 17'h14100 : 17'h0;
      checks++;
      if ({out_valid, out} !== want) begin
        errors++; $display("FAIL skew_c%0d: valid/out=%h want %h", c + 1, {out_valid, out}, want);
      end
      if (c == 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy: got %b want 1", busy); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ps [3];
    logic [15:0] wo [3];
    logic [16:0] want;
    ps = '{16'h0000, 16'h3F80, 16'h4000};
    wo = '{16'h4100, 16'h4110, 16'h4120};
    set_lanes(16'h3F80);
    for (int c = 0; c < DEPTH + 4; c++) begin
      in_valid = (c < 3); psum_in = (c < 3) ? ps[c] : 16'h0;
      if (c == 0) begin
        #1;
        checks++;
        if (wt_ready !== 1'b0) begin errors++; $display("FAIL ready_inval: got %b want 0", wt_ready); end
      end
      tick();
      want = (c + 1 >= DEPTH && c + 1 < DEPTH + 3) ? {1'b1, wo[c+1-DEPTH]} : 17'h0;
      checks++;
      if ({out_valid, out} !== want) begin
        errors++; $display("FAIL b2b_c%0d: valid/out=%h want %h", c + 1, {out_valid, out}, want);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturate_denormal();
    load_weights(16'h7F00, DEPTH);
    set_lanes(16'h7F00);
    run_token("saturate", 16'h0000, 16'h7F7F);
    load_weights(16'h0001, DEPTH);
    set_lanes(16'h3F80);
    run_token("denormal", 16'h3F80, 16'h3F80);
    run_token("zero_sum", 16'h0000, 16'h0000);
  endtask

  task automatic test_no_load_and_reset();
    int seen;
    do_reset();
    load_weights(16'h3F80, 4);
    set_lanes(16'h3F80);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin tick(); if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL drop_valid: saw %0d outputs want 0", seen); end
    do_reset();
    load_weights(16'h3F80, DEPTH - 1);
    checks++;
    if (wt_loaded !== 1'b0) begin errors++; $display("FAIL cnt_restart: loaded=%b want 0", wt_loaded); end
    load_weights(16'h3F80, 1);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0; tick(); rst = 1'b1;
    checks++;
    if (busy !== 1'b0 || wt_loaded !== 1'b0) begin
      errors++; $display("FAIL mid_reset: busy=%b loaded=%b want 0 0", busy, wt_loaded);
    end
    seen = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin tick(); if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_reset_out: saw %0d outputs want 0", seen); end
  endtask
`endif

  initial begin
    rst = 1'b0; wt_valid = 1'b0; wt_swap = 1'b0; in_valid = 1'b0;
    wt_data = 16'h0; psum_in = 16'h0; ifmap = '0;
    test_reset();
`ifdef BFP16_PE_COL_PREFETCH_EN
    test_prefetch();
`else
    test_load();
    test_compute_skewed();
    test_back_to_back();
    test_saturate_denormal();
    test_no_load_and_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
